// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits on one shared segment bus.
// Hex glyph decode, refresh scan with dead time, blanking, decimal points, leading-zero suppression.
module sevenseg_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int DEAD_CYCLES    = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic                    lz_suppress,
   output logic [0:6]              hex,
   output logic                    dpout,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] P_DEAD = PW'(DEAD_CYCLES);
   localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [0:6] SEG_OFF = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
   localparam logic DP_OFF = SEG_ACTIVE_LOW;

   logic [PW-1:0]           prescaler;
   logic [IW-1:0]           index;
   logic [4*NUM_DIGITS-1:0] shadow_value;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic [4*NUM_DIGITS-1:0] active_value;
   logic [NUM_DIGITS-1:0]   active_dp;

   logic                    slot_end;
   logic                    wrap;

   logic [3:0]              nibble;
   logic                    dp_bit;
   logic                    visible;
   logic [NUM_DIGITS-1:0]   onehot;
   logic [NUM_DIGITS-1:0]   suppressed;
   logic                    zero_run;
   logic [0:6]              glyph_low;
   logic [0:6]              hex_d;
   logic                    dpout_d;
   logic [NUM_DIGITS-1:0]   an_d;

   // Active-low glyph, bit 0 = segment a.
   function automatic logic [0:6] glyph(input logic [3:0] n);
      case (n)
         4'h0:    return 7'b0000001;
         4'h1:    return 7'b1001111;
         4'h2:    return 7'b0010010;
         4'h3:    return 7'b0000110;
         4'h4:    return 7'b1001100;
         4'h5:    return 7'b0100100;
         4'h6:    return 7'b0100000;
         4'h7:    return 7'b0001111;
         4'h8:    return 7'b0000000;
         4'h9:    return 7'b0001100;
         4'hA:    return 7'b0001000;
         4'hB:    return 7'b1100000;
         4'hC:    return 7'b0110001;
         4'hD:    return 7'b1000010;
         4'hE:    return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

   assign slot_end = (prescaler == P_LAST);
   assign wrap     = slot_end && (index == I_LAST);
   assign frame    = wrap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaler <= '0;
         index     <= '0;
      end else if (slot_end) begin
         prescaler <= '0;
         index     <= wrap ? '0 : index + 1'b1;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   // Active only moves at the frame boundary, so a frame never mixes old and new digits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_value <= '0;
         shadow_dp    <= '0;
         active_value <= '0;
         active_dp    <= '0;
      end else begin
         if (load) begin
            shadow_value <= value;
            shadow_dp    <= dp;
         end
         if (wrap) begin
            active_value <= load ? value : shadow_value;
            active_dp    <= load ? dp : shadow_dp;
         end
      end
   end

   always_comb begin
      nibble     = '0;
      dp_bit     = 1'b0;
      visible    = 1'b0;
      onehot     = '0;
      suppressed = '0;
      zero_run   = 1'b1;
      // Walk from the most significant digit down; a digit is a leading zero while everything above is zero.
      for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
         zero_run      = zero_run && (active_value[d*4 +: 4] == 4'h0);
         suppressed[d] = lz_suppress && (d > 0) && zero_run;
      end
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (index == IW'(d)) begin
            nibble    = active_value[d*4 +: 4];
            dp_bit    = active_dp[d];
            visible   = !blank[d] && !suppressed[d];
            onehot[d] = 1'b1;
         end
      end
   end

   always_comb begin
      glyph_low = glyph(nibble);
      hex_d     = SEG_OFF;
      dpout_d   = DP_OFF;
      an_d      = AN_OFF;
      if (visible) begin
         hex_d   = SEG_ACTIVE_LOW ? glyph_low : ~glyph_low;
         dpout_d = SEG_ACTIVE_LOW ? !dp_bit : dp_bit;
         // Segments settle during the dead window while all anodes stay off.
         if (prescaler >= P_DEAD) begin
            an_d = AN_ACTIVE_LOW ? ~onehot : onehot;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hex   <= SEG_OFF;
         dpout <= DP_OFF;
         an    <= AN_OFF;
      end else begin
         hex   <= hex_d;
         dpout <= dpout_d;
         an    <= an_d;
      end
   end

endmodule
